rx_l3_ctrl: RTL and testbench



---
 rtl/rx_pkg.sv | 23 ++
 rtl/rx_sat_counter.sv | 29 ++
 rtl/rx_l3_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rx_l3_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the receive layer-3 path: EtherTypes, sequencer
// states and parser-select encodings.
package rx_pkg;

  localparam logic [15:0] ETH_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_ARP  = 16'h0806;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IPV4  = 3'd1,
    ST_ARP   = 3'd2,
    ST_DROP  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_CLEAR = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IPV4 = 2'd1,
    SEL_ARP  = 2'd2
  } sel_e;

endpackage

// File: rtl/rx_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module rx_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/rx_l3_ctrl.sv
// Routes each received frame to the IPv4 or ARP parser (or drops it), waits
// for the parser to finish, then pulses that parser's reset for one cycle.
module rx_l3_ctrl
  import rx_pkg::*;
#(
  parameter int DRAIN_MAX = 16,
  parameter int CNT_W     = 16
) (
  input  logic             RX_CLK,
  input  logic             rst,
  input  logic             ctrl_en,
  input  logic [15:0]      rx_ethertype,
  input  logic             rx_ethernet_data_v,
  input  logic             rx_ethernet_irq,
  input  logic             rx_ipv4_irq,
  input  logic             rx_arp_irq,
  output logic             ipv4_func_en,
  output logic             arp_func_en,
  output logic             ipv4_rst,
  output logic             arp_rst,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [CNT_W-1:0] ipv4_frame_cnt,
  output logic [CNT_W-1:0] arp_frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int DCNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_MAX - 1);

  state_e              state_q, state_d;
  sel_e                sel_q, sel_d;
  sel_e                dec_sel;
  logic [DCNT_W-1:0]   drain_q, drain_d;
  logic                pend_q, pend_d;
  logic                ipv4_rst_q, ipv4_rst_d;
  logic                arp_rst_q, arp_rst_d;
  logic                parser_irq;
  logic                inc_ipv4, inc_arp, inc_drop, inc_timeout;

  always_comb begin
    dec_sel = SEL_NONE;
    if (rx_ethertype == ETH_IPV4) begin
      dec_sel = SEL_IPV4;
    end else if (rx_ethertype == ETH_ARP) begin
      dec_sel = SEL_ARP;
    end
  end

  assign parser_irq = (sel_q == SEL_IPV4) ? rx_ipv4_irq : rx_arp_irq;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    drain_d      = drain_q;
    pend_d       = pend_q;
    ipv4_func_en = 1'b0;
    arp_func_en  = 1'b0;
    inc_ipv4     = 1'b0;
    inc_arp      = 1'b0;
    inc_drop     = 1'b0;
    inc_timeout  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Enable is decoded combinationally so the parser sees the first byte.
        if (ctrl_en && rx_ethernet_data_v) begin
          ipv4_func_en = (dec_sel == SEL_IPV4);
          arp_func_en  = (dec_sel == SEL_ARP);
          if (dec_sel == SEL_NONE) begin
            inc_drop = 1'b1;
            state_d  = rx_ethernet_irq ? ST_IDLE : ST_DROP;
          end else begin
            sel_d  = dec_sel;
            pend_d = 1'b0;
            if (rx_ethernet_irq) begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end else begin
              state_d = (dec_sel == SEL_IPV4) ? ST_IPV4 : ST_ARP;
            end
          end
        end
      end
      ST_IPV4, ST_ARP: begin
        ipv4_func_en = (state_q == ST_IPV4);
        arp_func_en  = (state_q == ST_ARP);
        if (rx_ethernet_irq) begin
          state_d = ST_DRAIN;
          drain_d = '0;
          pend_d  = 1'b0;
        end
      end
      ST_DRAIN: begin
        ipv4_func_en = (sel_q == SEL_IPV4);
        arp_func_en  = (sel_q == SEL_ARP);
        if (rx_ethernet_data_v) begin
          pend_d = 1'b1;
        end
        if (parser_irq) begin
          state_d = ST_CLEAR;
        end else if (drain_q == DRAIN_LAST) begin
          state_d     = ST_CLEAR;
          inc_timeout = 1'b1;
        end else begin
          drain_d = drain_q + DCNT_W'(1);
        end
      end
      ST_CLEAR: begin
        inc_ipv4 = (sel_q == SEL_IPV4);
        inc_arp  = (sel_q == SEL_ARP);
        sel_d    = SEL_NONE;
        pend_d   = 1'b0;
        // A byte seen while draining means the next frame's head is already gone.
        if (pend_q || rx_ethernet_data_v) begin
          state_d  = ST_DROP;
          inc_drop = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (rx_ethernet_irq) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
  end

  assign ipv4_rst_d = (state_d == ST_CLEAR) && (sel_q == SEL_IPV4);
  assign arp_rst_d  = (state_d == ST_CLEAR) && (sel_q == SEL_ARP);

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_NONE;
      drain_q    <= '0;
      pend_q     <= 1'b0;
      ipv4_rst_q <= 1'b0;
      arp_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      drain_q    <= drain_d;
      pend_q     <= pend_d;
      ipv4_rst_q <= ipv4_rst_d;
      arp_rst_q  <= arp_rst_d;
    end
  end

  assign ipv4_rst = ipv4_rst_q;
  assign arp_rst  = arp_rst_q;
  assign sel      = sel_q;
  assign busy     = (state_q != ST_IDLE);

  rx_sat_counter #(.CNT_W(CNT_W)) u_ipv4_cnt (
    .clk(RX_CLK), .clr(rst), .inc(inc_ipv4), .value(ipv4_frame_cnt)
  );
  rx_sat_counter #(.CNT_W(CNT_W)) u_arp_cnt (
    .clk(RX_CLK), .clr(rst), .inc(inc_arp), .value(arp_frame_cnt)
  );
  rx_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk(RX_CLK), .clr(rst), .inc(inc_drop), .value(drop_cnt)
  );
  rx_sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
    .clk(RX_CLK), .clr(rst), .inc(inc_timeout), .value(timeout_cnt)
  );

endmodule

// File: tb/tb_rx_l3_ctrl.sv
// Directed bench for rx_l3_ctrl: cycle table for the basic flows plus
// hand-written timeout, overlap, ctrl_en, reset and saturation sequences.
module tb_rx_l3_ctrl;

  logic        RX_CLK = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_en = 1'b0;
  logic [15:0] rx_ethertype = 16'h0000;
  logic        rx_ethernet_data_v = 1'b0;
  logic        rx_ethernet_irq = 1'b0;
  logic        rx_ipv4_irq = 1'b0;
  logic        rx_arp_irq = 1'b0;

  logic        ipv4_func_en, arp_func_en, ipv4_rst, arp_rst, busy;
  logic [1:0]  sel;
  logic [15:0] ipv4_frame_cnt, arp_frame_cnt, drop_cnt, timeout_cnt;

  logic        s_ipv4_en, s_arp_en, s_ipv4_rst, s_arp_rst, s_busy;
  logic [1:0]  s_sel;
  logic [3:0]  s_ipv4_cnt, s_arp_cnt, s_drop_cnt, s_timeout_cnt;

  rx_l3_ctrl dut (
    .RX_CLK(RX_CLK), .rst(rst), .ctrl_en(ctrl_en), .rx_ethertype(rx_ethertype),
    .rx_ethernet_data_v(rx_ethernet_data_v), .rx_ethernet_irq(rx_ethernet_irq),
    .rx_ipv4_irq(rx_ipv4_irq), .rx_arp_irq(rx_arp_irq),
    .ipv4_func_en(ipv4_func_en), .arp_func_en(arp_func_en),
    .ipv4_rst(ipv4_rst), .arp_rst(arp_rst), .sel(sel), .busy(busy),
    .ipv4_frame_cnt(ipv4_frame_cnt), .arp_frame_cnt(arp_frame_cnt),
    .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
  );

  // Narrow-counter instance so saturation is reachable in a few frames.
  rx_l3_ctrl #(.DRAIN_MAX(16), .CNT_W(4)) dut_small (
    .RX_CLK(RX_CLK), .rst(rst), .ctrl_en(ctrl_en), .rx_ethertype(rx_ethertype),
    .rx_ethernet_data_v(rx_ethernet_data_v), .rx_ethernet_irq(rx_ethernet_irq),
    .rx_ipv4_irq(rx_ipv4_irq), .rx_arp_irq(rx_arp_irq),
    .ipv4_func_en(s_ipv4_en), .arp_func_en(s_arp_en),
    .ipv4_rst(s_ipv4_rst), .arp_rst(s_arp_rst), .sel(s_sel), .busy(s_busy),
    .ipv4_frame_cnt(s_ipv4_cnt), .arp_frame_cnt(s_arp_cnt),
    .drop_cnt(s_drop_cnt), .timeout_cnt(s_timeout_cnt)
  );

  always #5 RX_CLK = ~RX_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ce;
    logic [15:0] et;
    logic        dv, ei, ii, ai;
    logic [6:0]  exp;  // {ipv4_en, arp_en, ipv4_rst, arp_rst, sel[1:0], busy}
  } vec_t;

  vec_t        tbl[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [6:0]  obs;
  logic [6:0]  sm_obs;
  logic [15:0] c_ipv4, c_arp, c_drop, c_tmo;
  logic [3:0]  sc_ipv4, sc_drop, sc_arp, sc_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, return just after the next edge.
  task automatic cyc(input logic ce, input logic [15:0] et, input logic dv,
                     input logic ei, input logic ii, input logic ai);
    ctrl_en = ce; rx_ethertype = et; rx_ethernet_data_v = dv;
    rx_ethernet_irq = ei; rx_ipv4_irq = ii; rx_arp_irq = ai;
    @(negedge RX_CLK);
    obs    = {ipv4_func_en, arp_func_en, ipv4_rst, arp_rst, sel, busy};
    sm_obs = {s_ipv4_en, s_arp_en, s_ipv4_rst, s_arp_rst, s_sel, s_busy};
    c_ipv4 = ipv4_frame_cnt; c_arp = arp_frame_cnt; c_drop = drop_cnt; c_tmo = timeout_cnt;
    sc_ipv4 = s_ipv4_cnt; sc_arp = s_arp_cnt; sc_drop = s_drop_cnt; sc_tmo = s_timeout_cnt;
    @(posedge RX_CLK);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add(input logic ce, input logic [15:0] et, input logic dv,
                     input logic ei, input logic ii, input logic ai, input logic [6:0] exp);
    vec_t v;
    v.ce = ce; v.et = et; v.dv = dv; v.ei = ei; v.ii = ii; v.ai = ai; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    // IPv4 3-byte frame, parser irq one cycle into DRAIN
    add(1, 16'h0000, 0, 0, 0, 0, 7'b0000000);
    add(1, 16'h0800, 1, 0, 0, 0, 7'b1000000);
    add(1, 16'h0800, 1, 0, 0, 0, 7'b1000011);
    add(1, 16'h0800, 1, 1, 0, 0, 7'b1000011);
    add(1, 16'h0800, 0, 0, 1, 0, 7'b1000011);
    add(1, 16'h0000, 0, 0, 0, 0, 7'b0010011);
    add(1, 16'h0000, 0, 0, 0, 0, 7'b0000000);
    // Unknown EtherType 0x86DD
    add(1, 16'h86DD, 1, 0, 0, 0, 7'b0000000);
    add(1, 16'h86DD, 1, 0, 0, 0, 7'b0000001);
    add(1, 16'h86DD, 1, 1, 0, 0, 7'b0000001);
    add(1, 16'h0000, 0, 0, 0, 0, 7'b0000000);
    // One-byte ARP frame, parser irq on second DRAIN cycle
    add(1, 16'h0806, 1, 1, 0, 0, 7'b0100000);
    add(1, 16'h0806, 0, 0, 0, 0, 7'b0100101);
    add(1, 16'h0806, 0, 0, 0, 1, 7'b0100101);
    add(1, 16'h0000, 0, 0, 0, 0, 7'b0001101);
    add(1, 16'h0000, 0, 0, 0, 0, 7'b0000000);
    // One-byte IPv4 frame; the ARP irq must not end its drain
    add(1, 16'h0800, 1, 1, 0, 0, 7'b1000000);
    add(1, 16'h0800, 0, 0, 0, 1, 7'b1000011);
    add(1, 16'h0800, 0, 0, 1, 0, 7'b1000011);
    add(1, 16'h0000, 0, 0, 0, 0, 7'b0010011);
    add(1, 16'h0000, 0, 0, 0, 0, 7'b0000000);
    // ctrl_en low: frame ignored; lone frame-end irq in IDLE ignored
    add(0, 16'h0800, 1, 0, 0, 0, 7'b0000000);
    add(0, 16'h0800, 1, 1, 0, 0, 7'b0000000);
    add(1, 16'h0000, 0, 1, 0, 0, 7'b0000000);
    add(1, 16'h0000, 0, 0, 0, 0, 7'b0000000);

    // Reset state
    rst = 1'b1;
    repeat (3) idle();
    rst = 1'b0;
    idle();
    chk("reset_outputs", 32'(obs), 32'h0);
    chk("reset_ipv4_cnt", 32'(c_ipv4), 32'h0);
    chk("reset_arp_cnt", 32'(c_arp), 32'h0);
    chk("reset_drop_cnt", 32'(c_drop), 32'h0);
    chk("reset_timeout_cnt", 32'(c_tmo), 32'h0);

    foreach (tbl[i]) begin
      cyc(tbl[i].ce, tbl[i].et, tbl[i].dv, tbl[i].ei, tbl[i].ii, tbl[i].ai);
      chk($sformatf("vec%0d_outputs", i), 32'(obs), 32'(tbl[i].exp));
    end
    chk("tbl_ipv4_cnt", 32'(c_ipv4), 32'd2);
    chk("tbl_arp_cnt", 32'(c_arp), 32'd1);
    chk("tbl_drop_cnt", 32'(c_drop), 32'd1);
    chk("tbl_timeout_cnt", 32'(c_tmo), 32'd0);

    // ARP frame whose parser irq never arrives: 16 DRAIN cycles then CLEAR
    cyc(1, 16'h0806, 1, 0, 0, 0);
    cyc(1, 16'h0806, 1, 1, 0, 0);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (obs[3]) begin
        n = i;
        break;
      end
    end
    chk("timeout_drain_cycles", 32'(n), 32'd16);
    chk("timeout_clear_outputs", 32'(obs), 32'b0001101);
    idle();
    chk("timeout_cnt", 32'(c_tmo), 32'd1);
    chk("timeout_arp_cnt", 32'(c_arp), 32'd2);
    chk("timeout_idle", 32'(obs), 32'h0);

    // Next frame's bytes arrive while draining: counted as drop after CLEAR
    cyc(1, 16'h0800, 1, 0, 0, 0);
    cyc(1, 16'h0800, 1, 1, 0, 0);
    cyc(1, 16'h0800, 1, 0, 0, 0);
    cyc(1, 16'h0800, 1, 0, 1, 0);
    cyc(1, 16'h0800, 1, 0, 0, 0);
    chk("pend_clear_outputs", 32'(obs), 32'b0010011);
    cyc(1, 16'h0800, 1, 1, 0, 0);
    chk("pend_drop_outputs", 32'(obs), 32'b0000001);
    idle();
    chk("pend_idle", 32'(obs), 32'h0);
    chk("pend_drop_cnt", 32'(c_drop), 32'd2);
    chk("pend_ipv4_cnt", 32'(c_ipv4), 32'd3);
    cyc(1, 16'h0800, 1, 0, 0, 0);
    chk("after_pend_first_byte", 32'(obs), 32'b1000000);
    cyc(1, 16'h0800, 1, 1, 0, 0);
    cyc(1, 16'h0000, 0, 0, 1, 0);
    idle();
    chk("after_pend_clear", 32'(obs), 32'b0010011);
    idle();
    chk("after_pend_ipv4_cnt", 32'(c_ipv4), 32'd4);

    // ctrl_en dropped mid-frame: frame still completes and is counted
    cyc(1, 16'h0800, 1, 0, 0, 0);
    cyc(0, 16'h0800, 1, 0, 0, 0);
    chk("ctrl_off_mid_en", 32'(obs), 32'b1000011);
    cyc(0, 16'h0800, 1, 1, 0, 0);
    cyc(0, 16'h0000, 0, 0, 1, 0);
    cyc(0, 16'h0000, 0, 0, 0, 0);
    chk("ctrl_off_mid_clear", 32'(obs), 32'b0010011);
    cyc(0, 16'h0000, 0, 0, 0, 0);
    chk("ctrl_off_mid_ipv4_cnt", 32'(c_ipv4), 32'd5);

    // Reset in the middle of a frame
    cyc(1, 16'h0800, 1, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 16'h0800, 1, 0, 0, 0);
    rst = 1'b0;
    idle();
    chk("midrst_outputs", 32'(obs), 32'h0);
    chk("midrst_ipv4_cnt", 32'(c_ipv4), 32'd0);

    // Saturation: 17 IPv4 frames and 20 dropped frames
    for (int i = 0; i < 17; i++) begin
      cyc(1, 16'h0800, 1, 1, 0, 0);
      cyc(1, 16'h0000, 0, 0, 1, 0);
      idle();
      idle();
    end
    for (int i = 0; i < 20; i++) cyc(1, 16'h86DD, 1, 1, 0, 0);
    idle();
    chk("sat_small_ipv4_cnt", 32'(sc_ipv4), 32'hF);
    chk("sat_small_drop_cnt", 32'(sc_drop), 32'hF);
    chk("sat_small_arp_cnt", 32'(sc_arp), 32'h0);
    chk("sat_small_timeout_cnt", 32'(sc_tmo), 32'h0);
    chk("sat_small_idle", 32'(sm_obs), 32'h0);
    chk("sat_wide_ipv4_cnt", 32'(c_ipv4), 32'd17);
    chk("sat_wide_drop_cnt", 32'(c_drop), 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
